// File: rtl/ddr_frame_writer.sv
// ddr_frame_writer
// Packs a 16-bit RGB565 pixel stream into 256-bit words, buffers them in a
// show-ahead FIFO and writes them to DDR as fixed-length AXI bursts, forming
// a linear frame buffer. All logic runs in the DDR phy clock domain.
//
// Optional feature (macro DDR_FRAME_WRITER_PINGPONG_EN): two frame buffers
// with alternating base addresses, an o_buf_sel output, and a check of
// axi_wusero_last against the internal beat counter.
//
// Ports:
//   clk, rst            phy clock, asynchronous active-high reset
//   i_vsync             frame sync level; rising edge starts a frame
//   i_de, i_data        pixel valid and RGB565 pixel
//   axi_aw*             write address channel (fixed length, constant user)
//   axi_wdata/wstrb     write data (FIFO head) and constant all-ones strobe
//   axi_wready          controller consumes axi_wdata this cycle
//   axi_wusero_last     controller's last-beat flag (optional feature only)
//   o_overflow          sticky: a packed word was dropped on a full FIFO
//   o_frame_done        one-cycle pulse after the final burst of a frame
//   o_buf_sel           buffer being written (optional feature only)
module ddr_frame_writer #(
  parameter int unsigned H_ACT      = 1280,
  parameter int unsigned V_ACT      = 720,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter logic [27:0] FRAME_BASE = 28'h0000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_vsync,
  input  logic         i_de,
  input  logic [15:0]  i_data,
  output logic [27:0]  axi_awaddr,
  output logic         axi_awuser_ap,
  output logic [3:0]   axi_awuser_id,
  output logic [3:0]   axi_awlen,
  output logic         axi_awvalid,
  input  logic         axi_awready,
  output logic [255:0] axi_wdata,
  output logic [31:0]  axi_wstrb,
  input  logic         axi_wready,
  input  logic         axi_wusero_last,
  output logic         o_overflow,
  output logic         o_frame_done
`ifdef DDR_FRAME_WRITER_PINGPONG_EN
  ,
  output logic         o_buf_sel
`endif
);

  localparam int unsigned FRAME_WORDS = H_ACT * V_ACT / 16;
  localparam int unsigned BURSTS      = FRAME_WORDS / BURST_LEN;
  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C     = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] BURST_C     = (AW+1)'(BURST_LEN);
  localparam logic [27:0] ADDR_STEP   = 28'(8 * BURST_LEN);
  localparam logic [27:0] ALT_BASE    = FRAME_BASE + 28'(8 * FRAME_WORDS);

  typedef enum logic [1:0] {StIdle, StAw, StWdata} state_e;

  state_e        r_state, w_state_next;
  logic          r_vsync, r_sof_pend;
  logic [3:0]    r_pix_cnt;
  logic [255:0]  r_pack;
  logic          r_push;
  logic [255:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic [31:0]   r_word_cnt, r_burst_cnt, r_beat;
  logic [27:0]   r_awaddr;
  logic          r_overflow, r_frame_done;

  logic          w_service, w_full, w_push_ok, w_pop, w_last_pop, w_pix_ok;
  logic [27:0]   w_base;
  logic          w_wlast_err;

  assign w_service  = (r_state == StIdle) && r_sof_pend;
  assign w_full     = (r_cnt == DEPTH_C);
  assign w_push_ok  = r_push && !w_full;
  assign w_pop      = (r_state == StWdata) && axi_wready;
  assign w_last_pop = w_pop && (r_beat == BURST_LEN - 1);
  // Count the push in flight so the pixel right after the frame's last word is refused.
  assign w_pix_ok   = i_de && !r_sof_pend && ((r_word_cnt + 32'(w_push_ok)) < FRAME_WORDS);

`ifdef DDR_FRAME_WRITER_PINGPONG_EN
  logic r_buf_sel, r_started;
  // The first frame after reset stays in buffer 0; later frames alternate.
  assign w_base      = (r_started ? ~r_buf_sel : r_buf_sel) ? ALT_BASE : FRAME_BASE;
  assign w_wlast_err = w_pop && (axi_wusero_last != (r_beat == BURST_LEN - 1));
  assign o_buf_sel   = r_buf_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_sel <= 1'b0;
      r_started <= 1'b0;
    end else if (w_service) begin
      r_buf_sel <= r_started ? ~r_buf_sel : r_buf_sel;
      r_started <= 1'b1;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = axi_wusero_last;
  assign w_base        = FRAME_BASE;
  assign w_wlast_err   = 1'b0;
`endif

  // Start-of-frame detection; a pending edge waits for the write FSM to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync    <= 1'b0;
      r_sof_pend <= 1'b0;
    end else begin
      r_vsync <= i_vsync;
      if (i_vsync && !r_vsync) r_sof_pend <= 1'b1;
      else if (w_service)      r_sof_pend <= 1'b0;
    end
  end

  // Packer: shift right so the first pixel of a group ends up in [15:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_cnt <= 4'd0;
      r_pack    <= '0;
      r_push    <= 1'b0;
    end else if (w_service) begin
      r_pix_cnt <= 4'd0;
      r_push    <= 1'b0;
    end else begin
      r_push <= w_pix_ok && (r_pix_cnt == 4'd15);
      if (w_pix_ok) begin
        r_pack    <= {i_data, r_pack[255:16]};
        r_pix_cnt <= r_pix_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !w_service) r_mem[r_wr_ptr] <= r_pack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (w_service) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Frame bookkeeping, address and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_cnt   <= '0;
      r_burst_cnt  <= '0;
      r_beat       <= '0;
      r_awaddr     <= FRAME_BASE;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_pop && (r_burst_cnt == BURSTS - 1);
      if ((r_state == StAw) && axi_awready) r_beat <= '0;
      else if (w_pop)                       r_beat <= r_beat + 32'd1;
      if (w_service) begin
        r_word_cnt  <= '0;
        r_burst_cnt <= '0;
        r_awaddr    <= w_base;
        r_overflow  <= 1'b0;
      end else begin
        if (w_push_ok) r_word_cnt <= r_word_cnt + 32'd1;
        if (w_last_pop) begin
          r_burst_cnt <= r_burst_cnt + 32'd1;
          r_awaddr    <= r_awaddr + ADDR_STEP;
        end
        if ((r_push && w_full) || w_wlast_err) r_overflow <= 1'b1;
      end
    end
  end

  // Write FSM: state register, next state, outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (!r_sof_pend && (r_cnt >= BURST_C) && (r_burst_cnt < BURSTS)) w_state_next = StAw;
      end
      StAw:    if (axi_awready) w_state_next = StWdata;
      StWdata: if (w_last_pop)  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    axi_awvalid   = (r_state == StAw);
    axi_awaddr    = r_awaddr;
    axi_awuser_ap = 1'b0;
    axi_awuser_id = 4'h0;
    axi_awlen     = 4'(BURST_LEN - 1);
    axi_wstrb     = '1;
    axi_wdata     = r_mem[r_rd_ptr];
    o_overflow    = r_overflow;
    o_frame_done  = r_frame_done;
  end

endmodule

// File: tb/tb_ddr_frame_writer.sv
// Directed bench for ddr_frame_writer: 64x2 frame, 4-beat bursts, 8-deep FIFO.
// A second instance with a 16-word frame exercises FIFO overflow, which the
// 8-word frame cannot reach because its frame limit equals the FIFO depth.
module tb_ddr_frame_writer;
  localparam int BL = 4;

  logic         clk = 1'b0, rst = 1'b1;
  logic         vsync = 1'b0, de = 1'b0;
  logic [15:0]  data = '0;
  logic         awready = 1'b1, wready = 1'b1, wlast = 1'b0;
  logic [27:0]  awaddr, o_awaddr;
  logic         awuser_ap, o_awuser_ap, awvalid, o_awvalid;
  logic [3:0]   awuser_id, o_awuser_id, awlen, o_awlen;
  logic [255:0] wdata, o_wdata;
  logic [31:0]  wstrb, o_wstrb;
  logic         overflow, frame_done, o_ovf, o_fd;

  ddr_frame_writer #(.H_ACT(64), .V_ACT(2), .BURST_LEN(4), .FIFO_DEPTH(8),
                     .FRAME_BASE(28'h0)) u_dut (
    .clk(clk), .rst(rst), .i_vsync(vsync), .i_de(de), .i_data(data),
    .axi_awaddr(awaddr), .axi_awuser_ap(awuser_ap), .axi_awuser_id(awuser_id),
    .axi_awlen(awlen), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wready(wready),
    .axi_wusero_last(wlast), .o_overflow(overflow), .o_frame_done(frame_done)
`ifdef DDR_FRAME_WRITER_PINGPONG_EN
    , .o_buf_sel()
`endif
  );

  ddr_frame_writer #(.H_ACT(64), .V_ACT(4), .BURST_LEN(4), .FIFO_DEPTH(8),
                     .FRAME_BASE(28'h0)) u_dut_ovf (
    .clk(clk), .rst(rst), .i_vsync(vsync), .i_de(de), .i_data(data),
    .axi_awaddr(o_awaddr), .axi_awuser_ap(o_awuser_ap), .axi_awuser_id(o_awuser_id),
    .axi_awlen(o_awlen), .axi_awvalid(o_awvalid), .axi_awready(awready),
    .axi_wdata(o_wdata), .axi_wstrb(o_wstrb), .axi_wready(wready),
    .axi_wusero_last(wlast), .o_overflow(o_ovf), .o_frame_done(o_fd)
`ifdef DDR_FRAME_WRITER_PINGPONG_EN
    , .o_buf_sel()
`endif
  );

  always #5 clk = ~clk;

  int           total = 0, bad = 0;
  logic [27:0]  aw_q[$];
  logic [255:0] beat_q[$];
  int           pending = 0;
  int           fd_cnt = 0;
  bit           tog = 1'b0;

  // Mid-cycle monitor: after an accepted AW, the next BL wready cycles are beats.
  always @(negedge clk) begin
    if (!rst) begin
      if (pending > 0 && wready) begin
        beat_q.push_back(wdata);
        pending = pending - 1;
      end
      if (awvalid && awready) begin
        aw_q.push_back(awaddr);
        pending = BL;
      end
      if (frame_done) fd_cnt = fd_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) wready = ~wready;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_word(input int base, input int w);
    logic [255:0] r;
    for (int p = 0; p < 16; p++) r[16*p +: 16] = 16'(base + 16*w + p);
    return r;
  endfunction

  task automatic send(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      de   = 1'b1;
      data = 16'(base + i);
      tick();
    end
    de = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (beat_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 256'(beat_q.size()), 256'(n));
  endtask

  task automatic clear_logs();
    aw_q.delete();
    beat_q.delete();
    fd_cnt = 0;
  endtask

  initial begin
    bit stable;
    int k;

    // Reset values
    repeat (3) tick();
    check("rst_awaddr", 256'(awaddr), 256'h0);
    check("rst_awvalid", 256'(awvalid), 256'h0);
    check("rst_overflow", 256'(overflow), 256'h0);
    check("rst_frame_done", 256'(frame_done), 256'h0);
    check("awlen", 256'(awlen), 256'h3);
    check("wstrb", 256'(wstrb), 256'hFFFF_FFFF);
    check("awuser", 256'({awuser_ap, awuser_id}), 256'h0);
    rst = 1'b0;
    tick();

    // Full frame, index pixels
    pulse_vsync();
    send(0, 128);
    wait_beats(8, 100, "t1_beat_count");
    repeat (5) tick();
    check("t1_aw_count", 256'(aw_q.size()), 256'd2);
    if (aw_q.size() >= 2) begin
      check("t1_aw0", 256'(aw_q[0]), 256'h0);
      check("t1_aw1", 256'(aw_q[1]), 256'h20);
    end
    if (beat_q.size() >= 1) begin
      check("t1_beat0_lo", 256'(beat_q[0][15:0]), 256'h0);
      check("t1_beat0_hi", 256'(beat_q[0][255:240]), 256'hF);
    end
    for (int i = 0; i < 8 && i < beat_q.size(); i++)
      check($sformatf("t1_beat%0d", i), beat_q[i], exp_word(0, i));
    check("t1_frame_done", 256'(fd_cnt), 256'd1);
    check("t1_awaddr_end", 256'(awaddr), 256'h40);
    check("t1_overflow", 256'(overflow), 256'h0);
    // Pixels past the frame end are ignored
    send(16'h100, 32);
    repeat (20) tick();
    check("t1_no_extra_aw", 256'(aw_q.size()), 256'd2);
    check("t1_no_extra_done", 256'(fd_cnt), 256'd1);
    clear_logs();

    // awready held low
    awready = 1'b0;
    pulse_vsync();
    send(16'h1000, 64);
    k = 0;
    while (!awvalid && k < 20) begin
      tick();
      k++;
    end
    check("t2_awvalid", 256'(awvalid), 256'h1);
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!(awvalid === 1'b1 && awaddr === 28'h0 && beat_q.size() == 0)) stable = 1'b0;
    end
    check("t2_aw_stable", 256'(stable), 256'h1);
    awready = 1'b1;
    wait_beats(4, 30, "t2_beat_count");
    check("t2_aw_count", 256'(aw_q.size()), 256'd1);
    if (aw_q.size() >= 1) check("t2_aw0", 256'(aw_q[0]), 256'h0);
    for (int i = 0; i < 4 && i < beat_q.size(); i++)
      check($sformatf("t2_beat%0d", i), beat_q[i], exp_word(16'h1000, i));
    clear_logs();

    // wready toggling every cycle
    tog = 1'b1;
    pulse_vsync();
    send(16'h2000, 128);
    wait_beats(8, 200, "t3_beat_count");
    repeat (4) tick();
    tog = 1'b0;
    wready = 1'b1;
    repeat (4) tick();
    check("t3_beat_total", 256'(beat_q.size()), 256'd8);
    check("t3_aw_count", 256'(aw_q.size()), 256'd2);
    if (aw_q.size() >= 2) check("t3_aw1", 256'(aw_q[1]), 256'h20);
    for (int i = 0; i < 8 && i < beat_q.size(); i++)
      check($sformatf("t3_beat%0d", i), beat_q[i], exp_word(16'h2000, i));
    check("t3_frame_done", 256'(fd_cnt), 256'd1);
    clear_logs();

    // wready low while 160 pixels stream; vsync during the stalled burst
    wready = 1'b0;
    pulse_vsync();
    send(16'h3000, 160);
    repeat (3) tick();
    check("t4_ovf_set", 256'(o_ovf), 256'h1);
    check("t4_main_no_ovf", 256'(overflow), 256'h0);
    check("t4_aw_count", 256'(aw_q.size()), 256'd1);
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    wready = 1'b1;
    wait_beats(4, 20, "t4_beat_count");
    repeat (5) tick();
    check("t4_ovf_clear", 256'(o_ovf), 256'h0);
    check("t4_ovf_addr", 256'(o_awaddr), 256'h0);
    check("t4_addr", 256'(awaddr), 256'h0);
    check("t4_aw_after", 256'(aw_q.size()), 256'd1);
    for (int i = 0; i < 4 && i < beat_q.size(); i++)
      check($sformatf("t4_beat%0d", i), beat_q[i], exp_word(16'h3000, i));
    clear_logs();

    // vsync edge at beat 2 of a burst, stale words flushed
    wready = 1'b0;
    pulse_vsync();
    send(16'h4000, 96);
    repeat (3) tick();
    check("t5_aw_count", 256'(aw_q.size()), 256'd1);
    wready = 1'b1;
    tick();
    tick();
    vsync = 1'b1;
    tick();
    tick();
    tick();
    vsync = 1'b0;
    repeat (5) tick();
    check("t5_beat_count", 256'(beat_q.size()), 256'd4);
    for (int i = 0; i < 4 && i < beat_q.size(); i++)
      check($sformatf("t5_beat%0d", i), beat_q[i], exp_word(16'h4000, i));
    check("t5_addr_reset", 256'(awaddr), 256'h0);
    check("t5_no_stale_aw", 256'(aw_q.size()), 256'd1);
    send(16'h5000, 64);
    wait_beats(8, 40, "t5_beat_count2");
    check("t5_aw_count2", 256'(aw_q.size()), 256'd2);
    if (aw_q.size() >= 2) check("t5_aw1", 256'(aw_q[1]), 256'h0);
    if (beat_q.size() >= 8) begin
      check("t5_new_beat0", beat_q[4], exp_word(16'h5000, 0));
      check("t5_new_beat3", beat_q[7], exp_word(16'h5000, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
